// File: rtl/mem_bank_unit.sv
// Bank-switched address translator: maps 12-bit logical addresses to physical addresses
// through erasable/fixed/super bank registers, with a one-deep registered output stage.
module mem_bank_unit #(
  parameter int unsigned EB_W       = 3,
  parameter int unsigned SB_W       = 1,
  parameter int unsigned NUM_FBANKS = 40,
  parameter int unsigned OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reg_we,
  input  logic [1:0]       reg_sel,
  input  logic [15:0]      reg_wdata,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [11:0]      req_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_addr,
  output logic             out_fault,
  output logic [7:0]       fault_cnt,
  output logic [EB_W-1:0]  cur_eb,
  output logic [4:0]       cur_fb,
  output logic [SB_W-1:0]  cur_sb
);

  logic [EB_W-1:0]  r_eb;
  logic [4:0]       r_fb;
  logic [SB_W-1:0]  r_sb;
  logic             r_valid;
  logic [OUT_W-1:0] r_addr;
  logic             r_fault;
  logic [7:0]       r_fault_cnt;

  logic             w_req_ready;
  logic             w_accept;
  logic [7:0]       w_bank;
  logic [OUT_W-1:0] w_addr;
  logic             w_fault;

  assign w_req_ready = !r_valid || out_ready;
  assign w_accept    = req_valid && w_req_ready;

  // FB[4:3]=11 redirects the fixed window into the superbank-selected group.
  always_comb begin
    w_bank = {3'b000, r_fb};
    if (r_fb[4:3] == 2'b11) begin
      w_bank = ((8'(r_sb) + 8'd3) << 3) | {5'b00000, r_fb[2:0]};
    end
  end

  always_comb begin
    w_fault = 1'b0;
    w_addr  = '0;
    unique case (req_addr[11:10])
      2'b00: begin
        if (req_addr[9:8] == 2'b11) begin
          w_addr = OUT_W'({r_eb, req_addr[7:0]});
        end else begin
          w_addr = OUT_W'(req_addr[9:0]);
        end
      end
      2'b01: begin
        if (32'(w_bank) >= NUM_FBANKS) begin
          w_fault = 1'b1;
        end else begin
          w_addr = OUT_W'({w_bank, req_addr[9:0]});
        end
      end
      default: w_addr = OUT_W'(req_addr);
    endcase
  end

  // Requests in the same cycle as a write see the pre-write bank values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eb <= '0;
      r_fb <= '0;
      r_sb <= '0;
    end else if (reg_we) begin
      unique case (reg_sel)
        2'd0: r_eb <= reg_wdata[EB_W-1:0];
        2'd1: r_fb <= reg_wdata[14:10];
        2'd2: begin
          r_eb <= reg_wdata[EB_W-1:0];
          r_fb <= reg_wdata[14:10];
        end
        default: r_sb <= reg_wdata[SB_W-1:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_fault     <= 1'b0;
      r_fault_cnt <= 8'd0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_addr  <= w_addr;
        r_fault <= w_fault;
        if (w_fault && (r_fault_cnt != 8'hFF)) begin
          r_fault_cnt <= r_fault_cnt + 8'd1;
        end
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign out_valid = r_valid;
  assign out_addr  = r_addr;
  assign out_fault = r_fault;
  assign fault_cnt = r_fault_cnt;
  assign cur_eb    = r_eb;
  assign cur_fb    = r_fb;
  assign cur_sb    = r_sb;

endmodule
